// File: rtl/trace_stack.sv
// trace_stack: LIFO of DPLL variable assignments with registered top-of-stack, depth and decision level.
// Optional TRACE_STATS_EN macro enables the max_depth high-water register; otherwise max_depth_o is 0.
module trace_stack #(
  parameter int VAR_BITS = 5,
  parameter int DEPTH    = 32
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                push_trace_i,
  input  logic [VAR_BITS-1:0] var_in_trace_i,
  input  logic                val_in_trace_i,
  input  logic                type_in_trace_i,
  input  logic                pop_trace_i,
  output logic [VAR_BITS-1:0] var_out_trace_o,
  output logic                val_out_trace_o,
  output logic                type_out_trace_o,
  output logic                empty_trace_o,
  output logic                full_trace_o,
  output logic [VAR_BITS:0]   count_o,
  output logic [VAR_BITS:0]   decision_level_o,
  output logic                overflow_o,
  output logic                underflow_o,
  output logic [VAR_BITS:0]   max_depth_o
);
  localparam int CW = VAR_BITS + 1;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef struct packed {
    logic [VAR_BITS-1:0] v;
    logic                val;
    logic                typ;
  } ent_t;
  ent_t           mem [DEPTH];
  ent_t           top_q, top_d, in_e, below;
  logic [CW-1:0]  count_q, count_d, dl_q, dl_d;
  logic           ovf_q, ovf_d, unf_q, unf_d;
  logic           empty, full, rep, psh, pp, we;
  logic [AW-1:0]  wr_idx;
  assign in_e   = '{v: var_in_trace_i, val: val_in_trace_i, typ: type_in_trace_i};
  assign empty  = count_q == '0;
  assign full   = count_q == CW'(DEPTH);
  // Entry just below the top; becomes the new top on a plain pop.
  assign below  = count_q > CW'(1) ? mem[AW'(count_q - CW'(2))] : '0;
  assign wr_idx = AW'(rep ? count_q - CW'(1) : count_q);
  always_comb begin
    rep     = push_trace_i && pop_trace_i && !empty;
    psh     = push_trace_i && (pop_trace_i ? empty : !full);
    pp      = pop_trace_i && !push_trace_i && !empty;
    we      = rep || psh;
    count_d = psh ? count_q + CW'(1) : pp ? count_q - CW'(1) : count_q;
    dl_d    = dl_q + CW'(we && !in_e.typ) - CW'((rep || pp) && !top_q.typ);
    top_d   = we ? in_e : pp ? below : top_q;
    ovf_d   = ovf_q || (push_trace_i && !pop_trace_i && full);
    unf_d   = unf_q || (pop_trace_i && !push_trace_i && empty);
  end
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
      dl_q    <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dl_q    <= dl_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  always_ff @(posedge clock_i) begin
    if (we && !reset_i) mem[wr_idx] <= in_e;
  end
`ifdef TRACE_STATS_EN
  logic [CW-1:0] max_q;
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) max_q <= '0;
    else if (count_d > max_q) max_q <= count_d;
  end
  assign max_depth_o = max_q;
`else
  assign max_depth_o = '0;
`endif
  assign var_out_trace_o  = top_q.v;
  assign val_out_trace_o  = top_q.val;
  assign type_out_trace_o = top_q.typ;
  assign empty_trace_o    = empty;
  assign full_trace_o     = full;
  assign count_o          = count_q;
  assign decision_level_o = dl_q;
  assign overflow_o       = ovf_q;
  assign underflow_o      = unf_q;
endmodule
